// File: rtl/matrix_alu_core_pkg.sv
// Shared opcodes and packed-matrix slice helpers for the matrix ALU.
// Element (row,col) is row-major, with element 0 in the most significant word.
package matrix_alu_core_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_KRON = 2'b11;

    // Row-major element index.
    function automatic int elem_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

    // LSB bit offset of element (row,col) in a bus holding nelem words of width w.
    function automatic int elem_lsb(input int row, input int col, input int cols,
                                    input int nelem, input int w);
        return (nelem - 1 - elem_idx(row, col, cols)) * w;
    endfunction

endpackage

// File: rtl/matrix_mult_unit.sv
// Combinational A x B; products and sums kept at full width, each element truncated.
// Result is AR x BC packed row-major; all zeros when inner dimensions disagree.
module matrix_mult_unit
    import matrix_alu_core_pkg::*;
#(
    parameter int W  = 8,
    parameter int AR = 2,
    parameter int AC = 2,
    parameter int BR = 2,
    parameter int BC = 2
) (
    input  logic [AR*AC*W-1:0] i_a,
    input  logic [BR*BC*W-1:0] i_b,
    output logic [AR*BC*W-1:0] o_c
);

    localparam int ACCW = 2 * W + $clog2(AC + 1);

    generate
        if (AC == BR) begin : g_valid
            logic [ACCW-1:0] w_acc;

            always_comb begin
                o_c   = '0;
                w_acc = '0;
                for (int i = 0; i < AR; i++) begin
                    for (int j = 0; j < BC; j++) begin
                        w_acc = '0;
                        for (int k = 0; k < AC; k++) begin
                            w_acc = w_acc
                                  + ACCW'(i_a[elem_lsb(i, k, AC, AR*AC, W) +: W])
                                  * ACCW'(i_b[elem_lsb(k, j, BC, BR*BC, W) +: W]);
                        end
                        o_c[elem_lsb(i, j, BC, AR*BC, W) +: W] = w_acc[W-1:0];
                    end
                end
            end
        end else begin : g_invalid
            assign o_c = '0;
        end
    endgenerate

endmodule

// File: rtl/matrix_alu_core.sv
// Registered matrix ALU: add, subtract, multiply or Kronecker product into C, 1-cycle latency.
// Smaller results sit in the top words of C with the rest zeroed; invalid dimensions give zero.
module matrix_alu_core
    import matrix_alu_core_pkg::*;
#(
    parameter int word_size     = 8,
    parameter int Amatrixrownum = 2,
    parameter int Amatrixcolnum = 2,
    parameter int Bmatrixrownum = 2,
    parameter int Bmatrixcolnum = 2
) (
    input  logic                                     clk,
    input  logic                                     resetn,
    input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0] A,
    input  logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0] B,
    input  logic [1:0]                               op,
    output logic [Amatrixrownum*Amatrixcolnum*Bmatrixrownum*Bmatrixcolnum*word_size-1:0] C
);

    localparam int W  = word_size;
    localparam int AR = Amatrixrownum;
    localparam int AC = Amatrixcolnum;
    localparam int BR = Bmatrixrownum;
    localparam int BC = Bmatrixcolnum;
    localparam int NA = AR * AC;
    localparam int NB = BR * BC;
    localparam int NC = NA * NB;
    localparam int CW = NC * W;
    localparam int MW = AR * BC * W;

    logic [CW-1:0] w_add;
    logic [CW-1:0] w_sub;
    logic [CW-1:0] w_mul;
    logic [CW-1:0] w_kron;
    logic [CW-1:0] w_sel;
    logic [MW-1:0] w_mm;
    logic [CW-1:0] r_c;

    generate
        if (AR == BR && AC == BC) begin : g_addsub
            always_comb begin
                w_add = '0;
                w_sub = '0;
                for (int k = 0; k < NA; k++) begin
                    w_add[(NC-1-k)*W +: W] = A[(NA-1-k)*W +: W] + B[(NB-1-k)*W +: W];
                    w_sub[(NC-1-k)*W +: W] = A[(NA-1-k)*W +: W] - B[(NB-1-k)*W +: W];
                end
            end
        end else begin : g_addsub_invalid
            assign w_add = '0;
            assign w_sub = '0;
        end
    endgenerate

    matrix_mult_unit #(
        .W  (W),
        .AR (AR),
        .AC (AC),
        .BR (BR),
        .BC (BC)
    ) u_mult (
        .i_a (A),
        .i_b (B),
        .o_c (w_mm)
    );

    always_comb begin
        w_mul = '0;
        w_mul[CW-1 -: MW] = w_mm;
    end

    // Kronecker block (i,j) is A(i,j) scaling all of B; fills C completely.
    always_comb begin
        w_kron = '0;
        for (int i = 0; i < AR; i++) begin
            for (int j = 0; j < AC; j++) begin
                for (int p = 0; p < BR; p++) begin
                    for (int q = 0; q < BC; q++) begin
                        w_kron[elem_lsb(i*BR + p, j*BC + q, AC*BC, NC, W) +: W] =
                            A[elem_lsb(i, j, AC, NA, W) +: W] *
                            B[elem_lsb(p, q, BC, NB, W) +: W];
                    end
                end
            end
        end
    end

    always_comb begin
        w_sel = '0;
        case (op)
            OP_ADD:  w_sel = w_add;
            OP_SUB:  w_sel = w_sub;
            OP_MUL:  w_sel = w_mul;
            OP_KRON: w_sel = w_kron;
            default: w_sel = '0;
        endcase
    end

    // resetn is active-high despite its name.
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_c <= '0;
        end else begin
            r_c <= w_sel;
        end
    end

    assign C = r_c;

endmodule

// File: tb/tb_matrix_alu_core.sv
// Directed self-checking bench for matrix_alu_core with default 2x2 parameters.
module tb_matrix_alu_core;

    logic         clk;
    logic         resetn;
    logic [31:0]  A;
    logic [31:0]  B;
    logic [1:0]   op;
    logic [127:0] C;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0]  A_DIR  = 32'h01020300;
    localparam logic [31:0]  B_DIR  = 32'h05060708;
    localparam logic [127:0] E_ADD  = {32'h06080A08, 96'h0};
    localparam logic [127:0] E_SUB  = {32'hFCFCFCF8, 96'h0};
    localparam logic [127:0] E_MUL  = {32'h13160F12, 96'h0};
    localparam logic [127:0] E_KRON = 128'h05060A0C_07080E10_0F120000_15180000;
    // 0xFF*0xFF + 0xFF*0xFF = 0x1FC02 -> low byte 0x02.
    localparam logic [127:0] E_FF_MUL  = {32'h02020202, 96'h0};
    localparam logic [127:0] E_FF_KRON = {16{8'h01}};
    localparam logic [127:0] E_FF_ADD  = {32'hFEFEFEFE, 96'h0};

    matrix_alu_core dut (
        .clk    (clk),
        .resetn (resetn),
        .A      (A),
        .B      (B),
        .op     (op),
        .C      (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]   seq_op  [4];
    logic [127:0] seq_exp [4];

    initial begin
        resetn = 1'b1;
        A      = A_DIR;
        B      = B_DIR;
        op     = 2'b10;

        step();
        chk("reset_edge1", C, 128'h0);
        op = 2'b11;
        step();
        chk("reset_edge2", C, 128'h0);

        resetn = 1'b0;
        op     = 2'b00;
        step();
        chk("add", C, E_ADD);
        op = 2'b01;
        step();
        chk("sub", C, E_SUB);
        op = 2'b10;
        step();
        chk("mul", C, E_MUL);
        op = 2'b11;
        step();
        chk("kron", C, E_KRON);

        // Change between edges must not show until the next edge.
        op = 2'b00;
        #2;
        chk("hold_between_edges", C, E_KRON);
        step();
        chk("add_after_hold", C, E_ADD);

        A  = 32'hFFFFFFFF;
        B  = 32'hFFFFFFFF;
        op = 2'b10;
        step();
        chk("ff_mul", C, E_FF_MUL);
        op = 2'b11;
        step();
        chk("ff_kron", C, E_FF_KRON);
        op = 2'b00;
        step();
        chk("ff_add_wrap", C, E_FF_ADD);
        op = 2'b01;
        step();
        chk("ff_sub_zero", C, 128'h0);

        A  = 32'h0;
        B  = B_DIR;
        op = 2'b00;
        step();
        chk("zero_plus_b", C, {B_DIR, 96'h0});

        A = A_DIR;
        seq_op[0] = 2'b11; seq_exp[0] = E_KRON;
        seq_op[1] = 2'b01; seq_exp[1] = E_SUB;
        seq_op[2] = 2'b10; seq_exp[2] = E_MUL;
        seq_op[3] = 2'b00; seq_exp[3] = E_ADD;
        for (int i = 0; i < 4; i++) begin
            op = seq_op[i];
            step();
            chk($sformatf("switch_%0d", i), C, seq_exp[i]);
        end

        op     = 2'b11;
        resetn = 1'b1;
        step();
        chk("midstream_reset", C, 128'h0);
        resetn = 1'b0;
        step();
        chk("after_reset_kron", C, E_KRON);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
